branch_target_buffer: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the fetch PC register. Each cycle it looks up the current fetch PC and produces the `take_predicted_pc` / `predicted_pc` pair the PC register consumes to redirect the next fetch. Execute-stage branch resolution trains it through a single update port. `fence.i` or context switch clears it through a bulk invalidate.

---
 rtl/branch_target_buffer.sv | 83 ++++++++
 tb/tb_branch_target_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// The lookup is combinational for the fetch PC, and the single update port trains the table.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  output logic        take_predicted_pc,
  output logic [31:0] predicted_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        invalidate_all
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [29:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_fetch_idx;
  logic [TAG_W-1:0] w_fetch_tag;
  logic             w_fetch_hit;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic             w_unused;

  assign w_fetch_idx = fetch_pc[IDX_W+1:2];
  assign w_fetch_tag = fetch_pc[31:IDX_W+2];
  assign w_upd_idx   = upd_pc[IDX_W+1:2];
  assign w_upd_tag   = upd_pc[31:IDX_W+2];
  assign w_unused    = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Lookup sees the pre-update entry; no bypass from the update port.
  always_comb begin
    w_fetch_hit       = fetch_valid && r_valid[w_fetch_idx] &&
                        (r_tag[w_fetch_idx] == w_fetch_tag);
    take_predicted_pc = w_fetch_hit && r_ctr[w_fetch_idx][1] && !reset;
    predicted_pc      = take_predicted_pc ? {r_target[w_fetch_idx], 2'b00} : 32'h0;
  end

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Table state: bulk invalidate takes priority over training.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
      end
    end else if (invalidate_all) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_taken) begin
          r_target[w_upd_idx] <= upd_target[31:2];
          if (r_ctr[w_upd_idx] != 2'b11) begin
            r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
          end
        end else if (r_ctr[w_upd_idx] != 2'b00) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target[31:2];
        r_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: expected lookup results are queued
// when a cycle's stimulus is driven and compared when the outputs settle.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        take_predicted_pc;
  logic [31:0] predicted_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        invalidate_all;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        take;
    logic [31:0] pred;
  } exp_t;

  exp_t sb[$];

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_pc          (fetch_pc),
    .fetch_valid       (fetch_valid),
    .take_predicted_pc (take_predicted_pc),
    .predicted_pc      (predicted_pc),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_taken         (upd_taken),
    .upd_target        (upd_target),
    .invalidate_all    (invalidate_all)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic take, input logic [31:0] pred);
    exp_t e;
    e.tag  = tag;
    e.take = take;
    e.pred = pred;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk_eq({e.tag, "_take"}, 32'(take_predicted_pc), 32'(e.take));
      chk_eq({e.tag, "_pred"}, predicted_pc, e.pred);
    end
  endtask

  // One cycle: drive after the edge, check mid-cycle, update sampled at the next edge.
  task automatic cyc(input string tag,
                     input logic [31:0] pc, input logic fv,
                     input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic inv,
                     input logic etake, input logic [31:0] epred);
    @(posedge clk); #1;
    fetch_pc       = pc;
    fetch_valid    = fv;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    invalidate_all = inv;
    push_exp(tag, etake, epred);
    @(negedge clk);
    compare_out();
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic etake,
                      input logic [31:0] epred);
    cyc(tag, pc, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, etake, epred);
  endtask

  task automatic look_upd(input string tag, input logic [31:0] pc,
                          input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                          input logic etake, input logic [31:0] epred);
    cyc(tag, pc, 1'b1, 1'b1, upc, ut, utgt, 1'b0, etake, epred);
  endtask

  initial begin
    reset          = 1'b1;
    fetch_pc       = 32'h100;
    fetch_valid    = 1'b1;
    upd_valid      = 1'b0;
    upd_pc         = 32'h0;
    upd_taken      = 1'b0;
    upd_target     = 32'h0;
    invalidate_all = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and allocation
    look    ("reset_state", 32'h100, 1'b0, 32'h0);
    look_upd("alloc_same",  32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    look    ("alloc_hit",   32'h100, 1'b1, 32'h200);
    cyc     ("fv_low", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Counter hysteresis and saturation (ctr 10 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 01 -> 10)
    look_upd("nt_pre",      32'h100, 32'h100, 1'b0, 32'h0,   1'b1, 32'h200);
    look_upd("ctr01",       32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    look_upd("ctr10",       32'h100, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    look_upd("ctr11",       32'h100, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    look_upd("ctr11_hold",  32'h100, 32'h100, 1'b0, 32'h0,   1'b1, 32'h200);
    look_upd("ctr10_nt",    32'h100, 32'h100, 1'b0, 32'h0,   1'b1, 32'h200);
    look_upd("ctr01_nt",    32'h100, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0);
    look_upd("ctr00",       32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    look_upd("ctr01_valid", 32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    look    ("ctr10_again", 32'h100, 1'b1, 32'h200);

    // Aliasing at index 0
    look_upd("alias_miss",  32'h140, 32'h140, 1'b0, 32'h0,   1'b0, 32'h0);
    look_upd("alias_keep",  32'h100, 32'h140, 1'b1, 32'h300, 1'b1, 32'h200);
    look    ("alias_new",   32'h140, 1'b1, 32'h300);
    look_upd("alias_evict", 32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);

    // Same-cycle lookup and update
    look_upd("same_old",    32'h100, 32'h100, 1'b1, 32'h400, 1'b1, 32'h200);
    look    ("same_new",    32'h100, 1'b1, 32'h400);

    // Invalidate drops the simultaneous update
    cyc     ("inv_pre", 32'h100, 1'b1, 1'b1, 32'h180, 1'b1, 32'h500, 1'b1, 1'b1, 32'h400);
    look    ("inv_100",     32'h100, 1'b0, 32'h0);
    look    ("inv_180",     32'h180, 1'b0, 32'h0);
    look    ("inv_140",     32'h140, 1'b0, 32'h0);

    // Reallocate, then async reset mid-cycle
    look_upd("realloc_pre", 32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    look    ("realloc_hit", 32'h100, 1'b1, 32'h200);
    #2 reset = 1'b1;
    #1 push_exp("rst_async", 1'b0, 32'h0);
    compare_out();
    @(posedge clk); #1;
    push_exp("rst_held", 1'b0, 32'h0);
    compare_out();
    reset = 1'b0;
    look    ("rst_after",   32'h100, 1'b0, 32'h0);

    // Top index, low PC bits ignored
    look_upd("top_pre",     32'h3C,  32'h3C, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    look    ("top_hit",     32'h3F,  1'b1, 32'hFFFF_FFFC);
    look    ("top_other",   32'h100, 1'b0, 32'h0);

    chk_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
